// File: rtl/draw_arb_pkg.sv
// Shared widths and FSM state encodings for the DrawMif sprite-engine arbiter.
package draw_arb_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 9;
  localparam int ROM_W = 4;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_LAUNCH     = 4'd1;
  localparam logic [3:0] ST_WAIT_BUSY  = 4'd2;
  localparam logic [3:0] ST_WAIT_READY = 4'd3;
  localparam logic [3:0] ST_DONE       = 4'd4;

  typedef enum logic [3:0] {
    IDLE       = ST_IDLE,
    LAUNCH     = ST_LAUNCH,
    WAIT_BUSY  = ST_WAIT_BUSY,
    WAIT_READY = ST_WAIT_READY,
    DONE       = ST_DONE
  } state_t;

endpackage

// File: rtl/draw_arb_prio.sv
// Fixed-priority picker: one-hot of the lowest-index set request bit.
module draw_arb_prio #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i] && !w_found) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates NUM_REQ draw layers onto one sprite engine and sequences draw/ready.
// Optional watchdog on the engine handshake is enabled with `DRAW_WATCHDOG_EN.
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MIN_DRAW_CYC = 20,
  parameter int TIMEOUT_CYC  = 2000000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   reqX,
  input  logic [NUM_REQ*Y_W-1:0]   reqY,
  input  logic [NUM_REQ*ROM_W-1:0] reqRom,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     draw,
  output logic [X_W-1:0]           xOrigin,
  output logic [Y_W-1:0]           yOrigin,
  output logic [ROM_W-1:0]         ROMId,
  input  logic                     ready,
  output logic                     busy,
  output logic                     timeout
);

  localparam int CNT_W = $clog2(MIN_DRAW_CYC + 1);
  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(MIN_DRAW_CYC);
  localparam logic [CNT_W-1:0] BUSY_LAST   = CNT_W'(MIN_DRAW_CYC - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_draw;
  logic                 r_busy;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [ROM_W-1:0]     r_rom;

  logic [NUM_REQ-1:0]   w_pick;
  logic [X_W-1:0]       w_x;
  logic [Y_W-1:0]       w_y;
  logic [ROM_W-1:0]     w_rom;
  logic                 w_normal;
  logic                 w_wd_hit;
  logic                 w_finish;

  draw_arb_prio #(.NUM_REQ(NUM_REQ)) u_prio (
    .i_req (req),
    .o_gnt (w_pick)
  );

  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_rom = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_x   = reqX[i*X_W +: X_W];
        w_y   = reqY[i*Y_W +: Y_W];
        w_rom = reqRom[i*ROM_W +: ROM_W];
      end
    end
  end

  // A draw ends either when the engine returns to idle, or when it never
  // left idle for MIN_DRAW_CYC cycles after launch (zero-length draw).
  assign w_normal = ready && ((r_state == WAIT_BUSY && r_cnt == BUSY_LAST) ||
                              r_state == WAIT_READY);
  assign w_finish = w_normal || w_wd_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_draw  <= 1'b0;
      r_busy  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_rom   <= '0;
    end else begin
      r_done <= '0;
      if (w_finish) begin
        r_state <= DONE;
        r_draw  <= 1'b0;
        r_done  <= r_grant;
        r_grant <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (|req && ready) begin
              r_state <= LAUNCH;
              r_grant <= w_pick;
              r_x     <= w_x;
              r_y     <= w_y;
              r_rom   <= w_rom;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end
          end
          LAUNCH: begin
            r_draw <= 1'b1;
            if (r_cnt == LAUNCH_LAST) begin
              r_state <= WAIT_BUSY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          WAIT_BUSY: begin
            if (!ready) begin
              r_state <= WAIT_READY;
              r_draw  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          WAIT_READY: r_state <= WAIT_READY;
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef DRAW_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            w_waiting;

  assign w_waiting = (r_state == WAIT_BUSY) || (r_state == WAIT_READY);
  assign w_wd_hit  = w_waiting && (r_wd == WD_LAST);

  // Counter saturates at its limit; the flag stays set until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_waiting) begin
        r_wd <= '0;
      end else if (r_wd != WD_LAST) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (w_wd_hit && !w_normal) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign grant   = r_grant;
  assign done    = r_done;
  assign draw    = r_draw;
  assign busy    = r_busy;
  assign xOrigin = r_x;
  assign yOrigin = r_y;
  assign ROMId   = r_rom;

endmodule
